regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the successor to the two-read/one-write register memory and sits between decode/issue and the writeback stage of the core. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, and x0 hard-wired to zero. A busy-bit scoreboard lets issue flag pending destinations and lets decode detect read-after-write hazards on multi-cycle results.

## Interface
- DWIDTH, default XLEN: register data width
- REG_CNT, default REG_CNT (package): number of architectural registers, including x0
- NRD, default 2: read port count (1..4)
- NWR, default 2: write port count (1..3); a higher index has higher priority
- AWIDTH, localparam = REG_AWIDTH: register address width
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- raddr  in  NRD×AWIDTH  read addresses
- rdata  out  NRD×DWIDTH  read data, combinational
- rhazard  out  NRD  read target is busy and is not cleared this cycle
- we  in  NWR  write enables
- waddr  in  NWR×AWIDTH  write addresses
- wdata  in  NWR×DWIDTH  write data
- set_en  in  1  issue marks a destination busy
- set_addr  in  AWIDTH  destination to mark busy
- busy_any  out  1  at least one busy bit is set (registered)

## Operation
- Storage covers registers 1..REG_CNT-1. A read of x0 returns 0 and has rhazard=0.
- Writes to x0 and set_en to x0 are ignored.
- Multiple writes to the same address in one cycle: the highest-index port with we=1 wins.
- Scoreboard:
  - Any accepted write to address A clears busy[A] at the next edge.
  - set_en to A sets busy[A].
  - If a set and a write target the same A in one cycle, the set wins and busy[A] stays 1.
  - set_en to a register that is already busy is legal; the bit stays 1. No counting is done.
- rhazard[p] = busy[raddr[p]] AND NOT (some we[k] with waddr[k]==raddr[p]).
- busy_any is the registered OR of the next-state busy vector.
- Reset clears all registers and busy bits. Reset overrides any write or set in the same cycle.

## Timing
- Write latency: data is visible at rdata on the cycle after the write edge, or the same cycle when bypass is enabled (see Configuration).
- Scoreboard latency: set_en at edge N gives busy=1 from cycle N+1. A write at edge N gives busy=0 from cycle N+1.
- Reset values:
  - all registers 0, all busy bits 0, busy_any=0
  - rdata=0 and rhazard=0 for every address
- A reset asserted mid-operation takes effect at the next edge. Any in-flight set or write from that cycle is lost.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: rdata[p] returns the winning same-cycle wdata when raddr[p] matches an active non-x0 write (write-first). Priority follows the write-port rule.
  - Undefined: rdata returns the stored value (read-before-write). rhazard still deasserts on a matching same-cycle write. Without bypass, decode must hold the instruction for one cycle.

## Structure
- Shared package holds XLEN, REG_CNT, REG_AWIDTH, and a `reg_addr_t` typedef.
- One sub-module, `regfile_wr_arb`, is natural. It takes we/waddr/wdata and produces, per register, a one-hot winning write-enable and the selected data. Both the storage update and the bypass path use it.

## Test plan
- Reset: write 0xDEADBEEF to x5, then hold rst_n=0 for one edge -> rdata(x5)=0, busy_any=0.
- x0: we[0]=1, waddr=0, wdata=0x1234 -> read x0 returns 0; set_en to x0 leaves busy_any=0.
- Priority: port0 writes 0x11 and port1 writes 0x22 to x7 in the same cycle -> x7 reads 0x22 afterwards.
- Scoreboard: set_en x9 at cycle 0 -> rhazard=1 for raddr=x9 at cycle 1. Write x9=0xAB at cycle 3 -> rhazard=0 in cycle 3. busy_any=0 from cycle 4.
- Set/clear collision: set_en x4 and a write to x4 in the same cycle -> busy[x4] remains 1, x4 holds the new data.
- Bypass: write x3=0x55 with raddr[1]=x3 in the same cycle -> rdata[1]=0x55 when REGFILE_BYPASS_EN is defined, otherwise the old value; both read 0x55 next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file with a busy scoreboard.
package regfile_mp_pkg;

  localparam int XLEN       = 32;
  localparam int REG_CNT    = 32;
  localparam int REG_AWIDTH = $clog2(REG_CNT);

  typedef logic [REG_AWIDTH-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and scoreboard bus between issue/decode/writeback (master) and the register file (slave).
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DWIDTH = XLEN,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);

  reg_addr_t [NRD-1:0]             raddr;
  logic      [NRD-1:0][DWIDTH-1:0] rdata;
  logic      [NRD-1:0]             rhazard;
  logic      [NWR-1:0]             we;
  reg_addr_t [NWR-1:0]             waddr;
  logic      [NWR-1:0][DWIDTH-1:0] wdata;
  logic                            set_en;
  reg_addr_t                       set_addr;
  logic                            busy_any;

  modport master (
    output raddr, we, waddr, wdata, set_en, set_addr,
    input  rdata, rhazard, busy_any
  );

  modport slave (
    input  raddr, we, waddr, wdata, set_en, set_addr,
    output rdata, rhazard, busy_any
  );

endinterface

// File: rtl/regfile_mp_wr_arb.sv
// Write arbiter: per register, decides whether any port writes it this cycle and which data wins
// (highest-index enabled port). x0 never receives a write.
module regfile_wr_arb
  import regfile_mp_pkg::*;
#(
  parameter int DWIDTH  = XLEN,
  parameter int REG_CNT = regfile_mp_pkg::REG_CNT,
  parameter int NWR     = 2
) (
  input  logic      [NWR-1:0]                 we,
  input  reg_addr_t [NWR-1:0]                 waddr,
  input  logic      [NWR-1:0][DWIDTH-1:0]     wdata,
  output logic      [REG_CNT-1:0]             wr_en,
  output logic      [REG_CNT-1:0][DWIDTH-1:0] wr_data
);

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    for (int r = 1; r < REG_CNT; r++) begin
      // Ascending scan: a later (higher-index) port overwrites an earlier match.
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k] == reg_addr_t'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wdata[k];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 tied to zero and a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN makes reads write-first against same-cycle writes.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DWIDTH  = XLEN,
  parameter int REG_CNT = regfile_mp_pkg::REG_CNT,
  parameter int NRD     = 2,
  parameter int NWR     = 2
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  localparam int AWIDTH = REG_AWIDTH;

  logic [REG_CNT-1:0][DWIDTH-1:0] regs_q;
  logic [REG_CNT-1:0]             busy_q;
  logic [REG_CNT-1:0]             busy_d;
  logic                           busy_any_q;
  logic [REG_CNT-1:0]             wr_en;
  logic [REG_CNT-1:0][DWIDTH-1:0] wr_data;

  regfile_wr_arb #(
    .DWIDTH  (DWIDTH),
    .REG_CNT (REG_CNT),
    .NWR     (NWR)
  ) u_wr_arb (
    .we      (bus.we),
    .waddr   (bus.waddr),
    .wdata   (bus.wdata),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

  // A write clears busy; a same-cycle set to the same register takes precedence.
  always_comb begin
    busy_d = busy_q & ~wr_en;
    if (bus.set_en && (bus.set_addr != '0) && (int'(bus.set_addr) < REG_CNT)) begin
      busy_d[bus.set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: the register array is reset explicitly because x-free reads after reset are required;
  // entry 0 is never written, so it stays a constant zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q     <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      for (int r = 1; r < REG_CNT; r++) begin
        if (wr_en[r]) regs_q[r] <= wr_data[r];
      end
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  always_comb begin
    bus.rdata   = '0;
    bus.rhazard = '0;
    for (int p = 0; p < NRD; p++) begin
      logic [AWIDTH-1:0] a;
      a = bus.raddr[p];
      if ((a != '0) && (int'(a) < REG_CNT)) begin
`ifdef REGFILE_BYPASS_EN
        bus.rdata[p] = wr_en[a] ? wr_data[a] : regs_q[a];
`else
        bus.rdata[p] = regs_q[a];
`endif
        bus.rhazard[p] = busy_q[a] && !wr_en[a];
      end
    end
  end

  assign bus.busy_any = busy_any_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int DW  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  regfile_mp_if #(.DWIDTH(DW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .DWIDTH  (DW),
    .REG_CNT (REG_CNT),
    .NRD     (NRD),
    .NWR     (NWR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.raddr    = '0;
    bus.we       = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.set_en   = 1'b0;
    bus.set_addr = '0;
  endtask

  // Advance one edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int port, input int addr, input logic [DW-1:0] data);
    bus.we[port]    = 1'b1;
    bus.waddr[port] = reg_addr_t'(addr);
    bus.wdata[port] = data;
  endtask

  task automatic setb(input int addr);
    bus.set_en   = 1'b1;
    bus.set_addr = reg_addr_t'(addr);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    bus.raddr[0] = 5'd5;
    bus.raddr[1] = 5'd31;
    #1;
    check("rst_rdata0", bus.rdata[0], 32'h0);
    check("rst_rdata1", bus.rdata[1], 32'h0);
    check("rst_rhazard", DW'(bus.rhazard), 32'h0);
    check("rst_busy_any", DW'(bus.busy_any), 32'h0);

    // Write x5, then reset overrides a same-cycle write and set
    wr(0, 5, 32'hDEADBEEF);
    tick();
    idle();
    bus.raddr[0] = 5'd5;
    #1;
    check("x5_written", bus.rdata[0], 32'hDEADBEEF);
    rst_n = 1'b0;
    wr(1, 5, 32'h1);
    setb(5);
    tick();
    rst_n = 1'b1;
    idle();
    bus.raddr[0] = 5'd5;
    #1;
    check("x5_after_rst", bus.rdata[0], 32'h0);
    check("busy_after_rst", DW'(bus.busy_any), 32'h0);
    check("rhz_after_rst", DW'(bus.rhazard[0]), 32'h0);

    // x0 ignores writes and sets
    wr(0, 0, 32'h1234);
    setb(0);
    tick();
    idle();
    #1;
    check("x0_read", bus.rdata[0], 32'h0);
    check("x0_rhazard", DW'(bus.rhazard[0]), 32'h0);
    check("x0_set_busy_any", DW'(bus.busy_any), 32'h0);

    // Write-port priority: port 1 beats port 0
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    tick();
    idle();
    bus.raddr[1] = 5'd7;
    #1;
    check("prio_x7", bus.rdata[1], 32'h22);

    // Scoreboard: set x9 at cycle 0, write at cycle 3
    setb(9);
    tick();
    idle();
    bus.raddr[0] = 5'd9;
    #1;
    check("sb_rhz_c1", DW'(bus.rhazard[0]), 32'h1);
    check("sb_busy_any_c1", DW'(bus.busy_any), 32'h1);
    tick();
    tick();
    wr(0, 9, 32'hAB);
    #1;
    check("sb_rhz_c3_wr", DW'(bus.rhazard[0]), 32'h0);
    check("sb_busy_any_c3", DW'(bus.busy_any), 32'h1);
    tick();
    idle();
    bus.raddr[0] = 5'd9;
    #1;
    check("sb_busy_any_c4", DW'(bus.busy_any), 32'h0);
    check("sb_x9_data", bus.rdata[0], 32'hAB);
    check("sb_rhz_c4", DW'(bus.rhazard[0]), 32'h0);

    // Two busy registers: clearing one keeps busy_any high
    setb(9);
    tick();
    setb(10);
    tick();
    idle();
    wr(1, 9, 32'h9);
    tick();
    idle();
    bus.raddr[0] = 5'd9;
    bus.raddr[1] = 5'd10;
    #1;
    check("two_busy_any", DW'(bus.busy_any), 32'h1);
    check("two_rhazard", DW'(bus.rhazard), 32'h2);
    wr(0, 10, 32'hA);
    tick();
    idle();
    #1;
    check("two_cleared", DW'(bus.busy_any), 32'h0);

    // Set/clear collision on x4: set wins, data lands
    setb(4);
    wr(1, 4, 32'h77);
    tick();
    idle();
    bus.raddr[1] = 5'd4;
    #1;
    check("coll_rhz", DW'(bus.rhazard[1]), 32'h1);
    check("coll_data", bus.rdata[1], 32'h77);
    check("coll_busy_any", DW'(bus.busy_any), 32'h1);
    setb(4);
    tick();
    idle();
    bus.raddr[1] = 5'd4;
    #1;
    check("reset_busy_set", DW'(bus.rhazard[1]), 32'h1);
    wr(0, 4, 32'h78);
    tick();
    idle();
    #1;
    check("coll_cleared", DW'(bus.busy_any), 32'h0);

    // Bypass vs read-before-write on x3
    wr(0, 3, 32'h10);
    tick();
    idle();
    wr(0, 3, 32'h55);
    bus.raddr[1] = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_cycle", bus.rdata[1], 32'h55);
`else
    check("byp_same_cycle", bus.rdata[1], 32'h10);
`endif
    tick();
    idle();
    bus.raddr[0] = 5'd3;
    bus.raddr[1] = 5'd3;
    #1;
    check("byp_next0", bus.rdata[0], 32'h55);
    check("byp_next1", bus.rdata[1], 32'h55);

    // Bypass follows port priority
    wr(0, 3, 32'hAA);
    wr(1, 3, 32'hBB);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_prio", bus.rdata[0], 32'hBB);
`else
    check("byp_prio", bus.rdata[0], 32'h55);
`endif
    tick();
    idle();
    bus.raddr[0] = 5'd3;
    #1;
    check("prio_x3", bus.rdata[0], 32'hBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
